// File: rtl/blob_source.sv
// blob_source: host-loaded blob buffer that streams its contents onto the
// blob_dout en/rdy interface, tagging the final word with eop.
module blob_source #(
   parameter int DIN_W    = 16,
   parameter int ADDR_W   = 12,
   parameter int BLOB_LEN = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DIN_W-1:0]  wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              blob_dout_en,
   input  logic              blob_dout_rdy,
   output logic              blob_dout_eop,
   output logic [DIN_W-1:0]  blob_dout
);

   // Four entries let the read pipeline run ahead of a stalled consumer and
   // still sustain one beat per cycle once rdy returns.
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOB_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DIN_W-1:0]  mem [2**ADDR_W];
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic              rd_last;

   logic [DIN_W-1:0]  rd_data_p0;
   logic              vld_p0;
   logic              last_p0;

   logic [DIN_W-1:0]  fifo_data [DEPTH];
   logic [DEPTH-1:0]  fifo_eop;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic [PTR_W+1:0]  pending;

   logic push, pop, empty, head_eop, eop_xfer, rd_ok;

   assign empty    = (count == '0);
   assign push     = vld_p0;
   assign pop      = !empty && blob_dout_rdy;
   assign head_eop = fifo_eop[rd_ptr];
   assign eop_xfer = pop && head_eop;
   assign rd_last  = (rd_addr == LAST_ADDR);

   // Words that will sit in the FIFO once the in-flight read lands; a new read
   // is only allowed if it is guaranteed a free slot.
   assign pending = {1'b0, count} + (PTR_W+2)'(vld_p0) - (PTR_W+2)'(pop);
   assign rd_ok   = (pending < (PTR_W+2)'(DEPTH));

   assign busy          = (state != S_IDLE);
   assign blob_dout_en  = !empty;
   assign blob_dout_eop = !empty && head_eop;
   assign blob_dout     = empty ? '0 : fifo_data[rd_ptr];

   // Next-state and read-issue decode.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (rd_ok) begin
               rd_en = 1'b1;
               if (rd_last) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (eop_xfer) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register; reset aborts any stream in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Read address counter, read-valid pipeline and done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr <= '0;
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
         done    <= 1'b0;
      end else begin
         if (state == S_IDLE && start) rd_addr <= '0;
         else if (rd_en)               rd_addr <= rd_addr + ADDR_W'(1);
         vld_p0  <= rd_en;
         last_p0 <= rd_en && rd_last;
         done    <= (state == S_DRAIN) && eop_xfer;
      end
   end

   // Buffer RAM: host write port (locked out while streaming), registered read.
   always_ff @(posedge clk) begin
      if (wr_en && !busy) mem[wr_addr] <= wr_data;
      if (rd_en)          rd_data_p0   <= mem[rd_addr];
   end

   // --- p0 -> FIFO: read data and its eop tag enter the output queue ---
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= rd_data_p0;
         fifo_eop[wr_ptr]  <= last_p0;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_blob_source.sv
// tb_blob_source: directed bench for blob_source (default blob plus a
// single-word blob instance).
module tb_blob_source;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [11:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        start = 1'b0;
   logic        busy, done, en, eop;
   logic        rdy = 1'b0;
   logic [15:0] dout;

   logic        w1_en = 1'b0;
   logic [11:0] w1_addr = '0;
   logic [15:0] w1_data = '0;
   logic        start1 = 1'b0;
   logic        busy1, done1, en1, eop1;
   logic        rdy1 = 1'b0;
   logic [15:0] dout1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   blob_source #(.DIN_W(16), .ADDR_W(12), .BLOB_LEN(4096)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .busy(busy), .done(done), .blob_dout_en(en),
      .blob_dout_rdy(rdy), .blob_dout_eop(eop), .blob_dout(dout)
   );

   blob_source #(.DIN_W(16), .ADDR_W(12), .BLOB_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(w1_en), .wr_addr(w1_addr), .wr_data(w1_data),
      .start(start1), .busy(busy1), .done(done1), .blob_dout_en(en1),
      .blob_dout_rdy(rdy1), .blob_dout_eop(eop1), .blob_dout(dout1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start and verify the two-edge latency before the first beat.
   task automatic start_seq();
      @(negedge clk);
      rdy   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("en_after_E0", en, 0);
      @(negedge clk);
      chk("en_after_E1", en, 0);
   endtask

   // mode 0: rdy=1, 1: random rdy, 2: rdy=0 for 100 cycles then 1.
   task automatic run_stream(input int mode, input int abort_at, input int inject_at);
      int         idx = 0;
      int         cyc = 0;
      bit         finished = 0;
      bit         first_seen = 0;
      bit         eop_sent = 0;
      bit         injected = 0;
      bit         pe = 0, pr = 0, pp = 0;
      logic [15:0] pd = '0;
      while (!finished && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         wr_en = 1'b0;
         if (eop_sent) begin
            chk("done_pulse", done, 1);
            chk("busy_at_done", busy, 0);
            chk("en_at_done", en, 0);
            chk("beat_count", idx, 4096);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            finished = 1;
         end else if (abort_at >= 0 && idx == abort_at) begin
            rst = 1'b0;
            #1;
            chk("abort_en", en, 0);
            chk("abort_eop", eop, 0);
            chk("abort_dout", dout, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            finished = 1;
         end else begin
            if (cyc == 1) chk("first_en_latency", en, 1);
            if (pe && !pr) begin
               chk("stall_en", en, 1);
               chk("stall_data", dout, pd);
               chk("stall_eop", eop, pp);
            end
            chk("done_early", done, 0);
            if (en) begin
               chk("data", dout, 32'(idx + 256));
               chk("eop", eop, (idx == 4095) ? 1 : 0);
               first_seen = 1;
            end else begin
               chk("eop_without_en", eop, 0);
               if (first_seen && mode != 1) chk("no_bubble", en, 1);
            end
            if (idx == inject_at && !injected) begin
               start   = 1'b1;
               wr_en   = 1'b1;
               wr_addr = 12'd5;
               wr_data = 16'hFFFF;
               injected = 1;
            end
            if (mode == 1)      rdy = 1'($urandom_range(0, 1));
            else if (mode == 2) rdy = (cyc > 100);
            else                rdy = 1'b1;
            if (en && rdy) begin
               if (eop) eop_sent = 1;
               idx++;
            end
            pe = en; pr = rdy; pd = dout; pp = eop;
         end
      end
      if (!finished) chk("stream_timeout", 0, 1);
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_en", en, 0);
      chk("rst_eop", eop, 0);
      chk("rst_dout", dout, 0);
      chk("rst_en1", en1, 0);
      rst = 1'b1;

      // Load word k = k + 0x100
      for (int k = 0; k < 4096; k++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = 12'(k);
         wr_data = 16'(k + 256);
      end
      @(negedge clk);
      wr_en = 1'b0;

      // Full-rate stream
      start_seq();
      run_stream(0, -1, -1);

      // Random backpressure
      start_seq();
      run_stream(1, -1, -1);

      // Long initial stall then full rate
      start_seq();
      run_stream(2, -1, -1);

      // start and write while busy are ignored; then immediate restart
      start_seq();
      run_stream(0, -1, 2);
      start_seq();
      run_stream(0, -1, -1);

      // Asynchronous abort at beat 1000, then a clean restart from word 0
      start_seq();
      run_stream(0, 1000, -1);
      @(negedge clk);
      rst = 1'b1;
      rdy = 1'b1;
      @(negedge clk);
      chk("post_abort_en", en, 0);
      chk("post_abort_busy", busy, 0);
      start_seq();
      run_stream(0, -1, -1);

      // Single-word blob
      @(negedge clk);
      w1_en   = 1'b1;
      w1_addr = 12'd0;
      w1_data = 16'hBEEF;
      @(negedge clk);
      w1_en  = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("len1_busy", busy1, 1);
      chk("len1_en_E0", en1, 0);
      @(negedge clk);
      chk("len1_en_E1", en1, 0);
      @(negedge clk);
      chk("len1_en", en1, 1);
      chk("len1_eop", eop1, 1);
      chk("len1_data", dout1, 16'hBEEF);
      rdy1 = 1'b1;
      @(negedge clk);
      chk("len1_done", done1, 1);
      chk("len1_busy_done", busy1, 0);
      chk("len1_en_after", en1, 0);
      chk("len1_eop_after", eop1, 0);
      @(negedge clk);
      chk("len1_done_once", done1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/blob_source.md
# blob_source

Feature-map transmitter for the accelerator's blob stream. A host loads a complete blob (W×H×C words, stored in the exact order the first layer consumes them) into an internal buffer. On `start`, the block streams that blob onto the `blob_dout_*` interface with en/rdy flow control and marks the last word with eop. It is the driving end of the same blob protocol the layer blocks receive on `blob_din_*`, and sits in front of the first layer or any layer under test.

## Interface
Parameters:
- `DIN_W`, default 16: word width, Q-format passthrough.
- `ADDR_W`, default 12: buffer address width.
- `BLOB_LEN`, default 4096: words per blob (8×8×64). Must satisfy 1 ≤ `BLOB_LEN` ≤ 2^`ADDR_W`.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: host write strobe.
- `wr_addr`, in, `ADDR_W`: host write address.
- `wr_data`, in, `DIN_W`: host write data.
- `start`, in, 1: one-cycle pulse that begins streaming.
- `busy`, out, 1: high from start accept until the last beat transfers.
- `done`, out, 1: one-cycle pulse after the last beat transfers.
- `blob_dout_en`, out, 1: output word valid.
- `blob_dout_rdy`, in, 1: downstream ready.
- `blob_dout_eop`, out, 1: marks the last word of the blob.
- `blob_dout`, out, `DIN_W`: output word.

## Operation
- Buffer: simple dual-port RAM, `2^ADDR_W` × `DIN_W`, with a registered read port (1-cycle read latency).
- Host writes (`wr_en`=1) are accepted only while `busy`=0. They are ignored while `busy`=1.
- State machine has three states:
  - IDLE → RUN on `start`=1. Clears the read counter, sets `busy`.
  - RUN issues reads at addresses 0,1,…,`BLOB_LEN`−1. Read data enters an output FIFO of at least 2 entries.
  - A read is issued only when (FIFO occupancy + reads in flight − pop this cycle) is less than the FIFO depth. The FIFO never overflows and no word is dropped.
  - RUN → DRAIN when address `BLOB_LEN`−1 has been issued.
  - DRAIN → IDLE when the beat carrying eop transfers. On that transition `busy` falls and `done` pulses for one cycle.
- `start` while `busy`=1 is ignored.
- `start` and `wr_en` in the same IDLE cycle: the write is performed and streaming starts. The first word read may already reflect that write if it targets address 0 (write-first is not required; the bench must not rely on either behaviour).
- Output: the FIFO head drives `blob_dout`, `blob_dout_en` = FIFO not empty, and `blob_dout_eop` = head is word index `BLOB_LEN`−1.
- Data is passed through unchanged. No arithmetic is performed and the width is preserved.
- A new blob may be started in the cycle after `done`. The buffer contents persist across runs.

## Timing
- Reset values: `busy`=0, `done`=0, `blob_dout_en`=0, `blob_dout_eop`=0, `blob_dout`=0. FIFO is emptied and state goes to IDLE. RAM contents are undefined.
- Asserting reset mid-stream aborts immediately (asynchronously). After release the block is in IDLE with no residual beats.
- Handshake:
  - A beat transfers on a rising edge where `blob_dout_en`=1 and `blob_dout_rdy`=1.
  - While `blob_dout_en`=1 and `blob_dout_rdy`=0, `blob_dout` and `blob_dout_eop` hold stable.
  - `blob_dout_en` never drops without a transfer.
- Latency: with the edge sampling `start` as E0, the read of address 0 is issued at E1 and `blob_dout_en` rises after E2.
- Throughput: one beat per cycle while `blob_dout_rdy` is held high. No bubbles after the first beat.
- `blob_dout_eop` is high only together with `blob_dout_en`, exactly once per blob.
- `done` pulses in the cycle after the eop transfer edge, and `busy`=0 in that same cycle.
- `BLOB_LEN`=1: the first beat carries eop.

## Test plan
- Write addr k = k+0x100 for k=0..4095. Pulse start with rdy tied 1 → 4096 consecutive beats 0x0100…0x10FF, en first high 2 edges after the start edge, eop only on 0x10FF, done pulses once.
- Random rdy (50%) on the same data → identical sequence, data and eop stable during stalls, no duplicates or losses, total 4096 beats.
- Hold rdy=0 for 100 cycles after start, then release → first beat 0x0100 stays stable the whole time, then the stream resumes at full rate.
- start pulse and wr_en (addr 5 = 0xFFFF) both while busy → stream unaffected (word 5 = 0x0105), no restart. After done, a second start streams 0x0100… again.
- Assert rst at beat 1000 → all outputs 0 immediately. After release and a new start, the stream restarts at word 0.
- `BLOB_LEN`=1 with addr 0 = 0xBEEF → single beat with en=1 and eop=1, then done.
